risc16_control_fsm: RTL and testbench

Multi-cycle control unit for the RiSC-16 datapath, placed directly upstream of the register file. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the register file's `MUX_tgt`, `MUX_rf` and `WE_rf` selects and the PC, IR, ALU and memory strobes around it, and waits on a request/acknowledge handshake to a variable-latency memory.

---
 rtl/risc16_control_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_risc16_control_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/risc16_control_fsm.sv
// rtl/risc16_control_fsm.sv - RiSC-16 multi-cycle control FSM with memory handshake and wait timeout
// Optional build macro HALT_DETECT_EN: JALR with nonzero imm7 stops the core in HALT.
module risc16_control_fsm #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic        alu_eq,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  MUX_pc,
    output logic [1:0]  alu_op,
    output logic [1:0]  MUX_alu2,
    output logic        MUX_rf,
    output logic [1:0]  MUX_tgt,
    output logic        WE_rf,
    output logic        mem_err,
    output logic        halted
);

    localparam int CNT_W = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_NAND  = 2'b01;
    localparam logic [1:0] ALU_PASSB = 2'b10;
    localparam logic [1:0] B_REG     = 2'b00;
    localparam logic [1:0] B_SIMM    = 2'b01;
    localparam logic [1:0] B_UIMM    = 2'b10;
    localparam logic [1:0] TGT_MEM   = 2'b00;
    localparam logic [1:0] TGT_ALU   = 2'b01;
    localparam logic [1:0] TGT_PC1   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [2:0]       opcode;
    logic             halt_cmd;
    logic             timeout_hit;
    logic             unused_bits;

    assign opcode = instruction[15:13];

`ifdef HALT_DETECT_EN
    assign halt_cmd    = (opcode == OP_JALR) && (instruction[6:0] != 7'd0);
    assign unused_bits = ^instruction[12:7];
`else
    assign halt_cmd    = 1'b0;
    assign unused_bits = ^instruction[12:0];
`endif

    // wait_q holds the number of earlier unacknowledged cycles, so this cycle is the MEM_TIMEOUT-th one
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ack &&
                         (32'(wait_q) == 32'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH: begin
                if (mem_ack)          state_d = S_DECODE;
                else if (timeout_hit) state_d = S_ERR;
                else                  wait_d  = wait_q + 1'b1;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_ADDI, OP_NAND, OP_LUI: state_d = S_WB;
                    OP_SW, OP_LW:                     state_d = S_MEM;
                    OP_BEQ:                           state_d = S_FETCH;
                    default:                          state_d = halt_cmd ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ack)          state_d = S_FETCH;
                else if (timeout_hit) state_d = S_ERR;
                else                  wait_d  = wait_q + 1'b1;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are decoded from the current state so rst can kill them without waiting for an edge
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        MUX_pc       = PC_INC;
        alu_op       = ALU_ADD;
        MUX_alu2     = B_REG;
        MUX_rf       = 1'b0;
        MUX_tgt      = TGT_MEM;
        WE_rf        = 1'b0;
        mem_err      = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            MUX_rf = (opcode == OP_SW) || (opcode == OP_BEQ);
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_ADD: begin
                            alu_op   = ALU_ADD;
                            MUX_alu2 = B_REG;
                        end
                        OP_NAND: begin
                            alu_op   = ALU_NAND;
                            MUX_alu2 = B_REG;
                        end
                        OP_LUI: begin
                            alu_op   = ALU_PASSB;
                            MUX_alu2 = B_UIMM;
                        end
                        OP_ADDI, OP_SW, OP_LW: begin
                            alu_op   = ALU_ADD;
                            MUX_alu2 = B_SIMM;
                        end
                        OP_BEQ: begin
                            pc_we  = 1'b1;
                            MUX_pc = alu_eq ? PC_BRANCH : PC_INC;
                        end
                        default: begin
                            if (!halt_cmd) begin
                                WE_rf   = 1'b1;
                                MUX_tgt = TGT_PC1;
                                pc_we   = 1'b1;
                                MUX_pc  = PC_REG;
                            end
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OP_SW);
                    alu_op       = ALU_ADD;
                    MUX_alu2     = B_SIMM;
                    if (mem_ack) begin
                        pc_we   = 1'b1;
                        MUX_pc  = PC_INC;
                        WE_rf   = (opcode == OP_LW);
                        MUX_tgt = TGT_MEM;
                    end
                end
                S_WB: begin
                    WE_rf   = 1'b1;
                    MUX_tgt = TGT_ALU;
                    pc_we   = 1'b1;
                    MUX_pc  = PC_INC;
                end
`ifdef HALT_DETECT_EN
                S_HALT:  halted = 1'b1;
`endif
                S_ERR:   mem_err = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_control_fsm.sv
// tb/tb_risc16_control_fsm.sv - scoreboard bench for risc16_control_fsm (MEM_TIMEOUT=4)
module tb_risc16_control_fsm;

    typedef logic [16:0] vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic        alu_eq = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  MUX_pc, alu_op, MUX_alu2, MUX_tgt;
    logic        MUX_rf, WE_rf, mem_err, halted;

    vec_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    vec_t  mon_e;
    string mon_n;
    vec_t  got;

    localparam logic [15:0] I_ADD   = 16'h0483;
    localparam logic [15:0] I_ADDI  = 16'h2285;
    localparam logic [15:0] I_NAND  = 16'h4483;
    localparam logic [15:0] I_LUI   = 16'h6123;
    localparam logic [15:0] I_BEQ   = 16'hC485;
    localparam logic [15:0] I_LW    = 16'hA804;
    localparam logic [15:0] I_SW    = 16'h8403;
    localparam logic [15:0] I_JALR  = 16'hE500;
    localparam logic [15:0] I_JALRH = 16'hE001;

    risc16_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .alu_eq(alu_eq), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .MUX_pc(MUX_pc), .alu_op(alu_op), .MUX_alu2(MUX_alu2), .MUX_rf(MUX_rf),
        .MUX_tgt(MUX_tgt), .WE_rf(WE_rf), .mem_err(mem_err), .halted(halted)
    );

    always #5 clk = ~clk;

    assign got = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, MUX_pc, alu_op, MUX_alu2,
                  MUX_rf, MUX_tgt, WE_rf, mem_err, halted};

    function automatic vec_t mk(bit req, bit we, bit asel, bit irwe, bit pcwe, bit [1:0] mpc,
                                bit [1:0] aop, bit [1:0] malu, bit mrf, bit [1:0] mtgt,
                                bit werf, bit err, bit hlt);
        return {req, we, asel, irwe, pcwe, mpc, aop, malu, mrf, mtgt, werf, err, hlt};
    endfunction

    function automatic vec_t z(bit mrf, bit err, bit hlt);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, mrf, 2'b00, 0, err, hlt);
    endfunction

    function automatic vec_t fetch(bit ack, bit mrf);
        return mk(1, 0, 0, ack, 0, 2'b00, 2'b00, 2'b00, mrf, 2'b00, 0, 0, 0);
    endfunction

    // One clock cycle: drive inputs just after the edge, record what the cycle must show
    task automatic cyc(input logic [15:0] ins, input bit ack, input bit eq,
                       input vec_t e, input string nm);
        instruction = ins;
        mem_ack     = ack;
        alu_eq      = eq;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input logic [15:0] ins, input bit [1:0] aop, input bit [1:0] malu,
                           input string nm);
        cyc(ins, 1, 0, fetch(1, 0), {nm, "_fetch"});
        cyc(ins, 1, 0, z(0, 0, 0), {nm, "_decode"});
        cyc(ins, 1, 0, mk(0, 0, 0, 0, 0, 2'b00, aop, malu, 0, 2'b00, 0, 0, 0), {nm, "_exec"});
        cyc(ins, 1, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 2'b01, 1, 0, 0), {nm, "_wb"});
    endtask

    task automatic front(input logic [15:0] ins, input bit mrf, input string nm);
        cyc(ins, 1, 0, fetch(1, mrf), {nm, "_fetch"});
        cyc(ins, 1, 0, z(mrf, 0, 0), {nm, "_decode"});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            n_tests++;
            if (got !== mon_e) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h", mon_n, got, mon_e);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cyc(I_SW, 1, 0, z(0, 0, 0), "reset_state");
        rst = 1'b0;

        run_alu(I_ADD, 2'b00, 2'b00, "add");
        run_alu(I_ADDI, 2'b00, 2'b01, "addi");
        run_alu(I_NAND, 2'b01, 2'b00, "nand");
        run_alu(I_LUI, 2'b10, 2'b10, "lui");

        front(I_BEQ, 1, "beq_t");
        cyc(I_BEQ, 1, 1, mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0), "beq_taken");
        front(I_BEQ, 1, "beq_n");
        cyc(I_BEQ, 1, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0), "beq_not_taken");

        front(I_LW, 0, "lw");
        cyc(I_LW, 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0, 2'b00, 0, 0, 0), "lw_exec");
        for (int i = 0; i < 3; i++)
            cyc(I_LW, 0, 0, mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 0, 2'b00, 0, 0, 0), "lw_mem_wait");
        cyc(I_LW, 1, 0, mk(1, 0, 1, 0, 1, 2'b00, 2'b00, 2'b01, 0, 2'b00, 1, 0, 0), "lw_mem_ack");

        for (int i = 0; i < 3; i++)
            cyc(I_SW, 0, 0, fetch(0, 1), "sw_fetch_wait");
        front(I_SW, 1, "sw");
        cyc(I_SW, 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0), "sw_exec");
        for (int i = 0; i < 3; i++)
            cyc(I_SW, 0, 0, mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0), "sw_mem_wait");
        cyc(I_SW, 1, 0, mk(1, 1, 1, 0, 1, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0), "sw_mem_ack");

        front(I_JALR, 0, "jalr");
        cyc(I_JALR, 1, 0, mk(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 2'b10, 1, 0, 0), "jalr_exec");

        front(I_SW, 1, "swto");
        cyc(I_SW, 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0), "swto_exec");
        for (int i = 0; i < 4; i++)
            cyc(I_SW, 0, 0, mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0), "swto_mem_wait");
        cyc(I_ADD, 1, 0, z(0, 1, 0), "err_latched");
        cyc(I_ADD, 1, 0, z(0, 1, 0), "err_held");
        rst = 1'b1;
        cyc(I_ADD, 1, 0, z(0, 0, 0), "err_reset");
        rst = 1'b0;
        cyc(I_ADD, 0, 0, fetch(0, 0), "err_cleared_fetch");
        cyc(I_SW, 1, 0, fetch(1, 1), "mid_fetch");
        cyc(I_SW, 1, 0, z(1, 0, 0), "mid_decode");
        cyc(I_SW, 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0), "mid_exec");
        cyc(I_SW, 0, 0, mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0), "mid_mem");
        rst = 1'b1;
        cyc(I_SW, 0, 0, z(0, 0, 0), "rst_mid_mem");
        rst = 1'b0;
        cyc(I_SW, 0, 0, fetch(0, 1), "refetch_after_rst");
        cyc(I_JALRH, 1, 0, fetch(1, 0), "jalrh_fetch");
        cyc(I_JALRH, 1, 0, z(0, 0, 0), "jalrh_decode");
`ifdef HALT_DETECT_EN
        cyc(I_JALRH, 1, 0, z(0, 0, 0), "halt_exec");
        cyc(I_JALRH, 1, 0, z(0, 0, 1), "halted");
        cyc(I_ADD, 1, 0, z(0, 0, 1), "halted_held");
`else
        cyc(I_JALRH, 1, 0, mk(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 2'b10, 1, 0, 0), "jalrh_exec");
        cyc(I_ADD, 1, 0, fetch(1, 0), "jalrh_next_fetch");
        cyc(I_ADD, 1, 0, z(0, 0, 0), "jalrh_next_decode");
`endif
        rst = 1'b1;
        cyc(I_ADD, 0, 0, z(0, 0, 0), "final_reset");
        rst = 1'b0;
        cyc(I_ADD, 1, 0, fetch(1, 0), "final_fetch");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
